scnn_cu_sequencer: RTL and testbench



---
 rtl/scnn_cu_sequencer_pkg.sv | 82 ++++++++
 rtl/scnn_cu_sequencer_if.sv | 12 +
 rtl/scnn_cu_sequencer_pkt_out_reg.sv | 45 ++++
 rtl/scnn_cu_sequencer.sv | 267 ++++++++++++++++++++++++++
 tb/tb_scnn_cu_sequencer.sv | 332 +++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/scnn_cu_sequencer_pkg.sv
// Packet format, opcodes, FSM states and packet builders shared by
// the CU sequencer and its output register.
package scnn_pkg;

    localparam int PCKT_WIDTH = 48;
    localparam int TYPE_LSB   = 40;
    localparam int SPIKE_BIT  = 39;
    localparam int RES_LSB    = 31;
    localparam int ACK_OP_LSB = 31;

    typedef logic [PCKT_WIDTH-1:0] pkt_t;

    typedef enum logic [2:0] {
        DT_WEIGHT   = 3'b000,
        DT_FMAP     = 3'b001,
        DT_CMD      = 3'b011,
        DT_CMDACK   = 3'b100,
        DT_SPIKERES = 3'b101
    } dtype_e;

    typedef enum logic [1:0] {
        OP_LOADW   = 2'b00,
        OP_LOADI   = 2'b01,
        OP_MAC_CFG = 2'b10,
        OP_MAC     = 2'b11
    } opcode_e;

    typedef enum logic [3:0] {
        S_IDLE,
        S_LW_CMD,
        S_LW_FETCH,
        S_LW_SEND,
        S_LW_ACK,
        S_CFG_CMD,
        S_CFG_ACK,
        S_MAC_CMD,
        S_IF_FETCH,
        S_IF_SEND,
        S_WAIT_RES,
        S_WAIT_ACK,
        S_DONE
    } state_e;

    function automatic pkt_t pack_cmd(
        input logic [4:0]  dest,
        input opcode_e     op,
        input logic [37:0] payload
    );
        return {dest, DT_CMD, op, payload};
    endfunction

    function automatic pkt_t pack_weight(
        input logic [4:0]  dest,
        input logic [39:0] row
    );
        return {dest, DT_WEIGHT, row};
    endfunction

    function automatic pkt_t pack_fmap(
        input logic [4:0] dest,
        input logic [4:0] bits
    );
        return {dest, DT_FMAP, 35'b0, bits};
    endfunction

    // {nums, start, stride, 12'b0}
    function automatic logic [37:0] loadw_payload();
        return {9'b0, 7'd5, 5'd0, 5'd1, 12'b0};
    endfunction

    // {ws, is, threshold, 18'b0}
    function automatic logic [37:0] cfg_payload(input logic [7:0] thr);
        return {10'b0, 1'b1, 1'b0, thr, 18'b0};
    endfunction

    // {last, nums, resin, resout, cmp, start, stride, out_start}
    function automatic logic [37:0] mac_payload();
        return {9'b0, 1'b0, 7'd5, 1'b0, 1'b1, 1'b1,
                5'd0, 5'd1, 8'd0};
    endfunction

endpackage

// File: rtl/scnn_cu_sequencer_if.sv
// Valid/ready packet channel between the sequencer and the CU.
interface scnn_cu_sequencer_if;
    import scnn_pkg::*;

    logic valid;
    logic ready;
    pkt_t pkt;

    modport master (output valid, output pkt, input ready);
    modport slave  (input valid, input pkt, output ready);

endinterface

// File: rtl/scnn_cu_sequencer_pkt_out_reg.sv
// One-entry output holding register: a loaded packet stays stable
// on the channel until the CU accepts it.
module scnn_pkt_out_reg
    import scnn_pkg::*;
(
    input  logic clk,
    input  logic rst,
    input  logic push_i,
    input  pkt_t pkt_i,
    output logic rdy_o,
    scnn_cu_sequencer_if.master out_if
);

    logic valid_q, valid_d;
    pkt_t pkt_q, pkt_d;

    // a new packet may enter in the same cycle the old one leaves
    assign rdy_o = !valid_q || out_if.ready;

    always_comb begin
        valid_d = valid_q;
        pkt_d   = pkt_q;
        if (valid_q && out_if.ready) begin
            valid_d = 1'b0;
        end
        if (push_i && rdy_o) begin
            valid_d = 1'b1;
            pkt_d   = pkt_i;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= 1'b0;
            pkt_q   <= '0;
        end else begin
            valid_q <= valid_d;
            pkt_q   <= pkt_d;
        end
    end

    assign out_if.valid = valid_q;
    assign out_if.pkt   = pkt_q;

endmodule

// File: rtl/scnn_cu_sequencer.sv
// Sequencer feeding weights, config and per-pixel ifmap windows to the
// spiking CU and storing the returned spike/residue results.
module scnn_cu_sequencer
    import scnn_pkg::*;
#(
    parameter logic [4:0] CU_ADDR   = 5'b10000,
    parameter logic [7:0] THRESHOLD = 8'd32,
    parameter int         IF_DIM    = 25
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    output logic              busy_o,
    output logic              done_o,
    output logic              err_o,
    output logic [4:0]        w_addr_o,
    input  logic [7:0]        w_rdata_i,
    output logic [4:0]        if_addr_o,
    input  logic [IF_DIM-1:0] if_rdata_i,
    scnn_cu_sequencer_if.master pkt_out_if,
    scnn_cu_sequencer_if.slave  pkt_in_if,
    output logic              res_we_o,
    output logic [8:0]        res_addr_o,
    output logic              res_spike_o,
    output logic [7:0]        res_residue_o
);

    localparam int OUT_DIM = IF_DIM - 4;
    localparam logic [4:0] LAST = 5'(OUT_DIM - 1);

    state_e      state_q, state_d;
    logic [2:0]  ky_q, ky_d;
    logic [2:0]  f_q, f_d;
    logic [4:0]  ox_q, ox_d;
    logic [4:0]  oy_q, oy_d;
    logic [39:0] wrow_q, wrow_d;
    logic [4:0]  frow_q, frow_d;
    logic        err_q, err_d;
    logic        res_we_q, res_we_d;
    logic [8:0]  res_addr_q, res_addr_d;
    logic        res_spike_q, res_spike_d;
    logic [7:0]  res_residue_q, res_residue_d;

    logic        push;
    pkt_t        pkt_nxt;
    logic        out_rdy;
    logic        in_rdy;
    logic        in_xfer;
    logic [2:0]  in_type;
    logic [1:0]  ack_op;
    logic        is_ack;
    logic        is_res;
    logic [2:0]  f_clamp;
    logic        unused_in_bits;

    assign in_rdy = state_q inside {S_LW_ACK, S_CFG_ACK,
                                    S_WAIT_RES, S_WAIT_ACK};
    assign in_xfer = in_rdy && pkt_in_if.valid;
    assign in_type = pkt_in_if.pkt[TYPE_LSB +: 3];
    assign ack_op  = pkt_in_if.pkt[ACK_OP_LSB +: 2];
    assign is_ack  = in_type == DT_CMDACK;
    assign is_res  = in_type == DT_SPIKERES;
    assign unused_in_bits = ^{pkt_in_if.pkt[47:43],
                              pkt_in_if.pkt[30:0]};

    // the sixth weight-fetch cycle only captures, so hold the address
    assign f_clamp   = (f_q > 3'd4) ? 3'd4 : f_q;
    assign w_addr_o  = 5'(ky_q) * 5'd5 + 5'(f_clamp);
    assign if_addr_o = oy_q + 5'(ky_q);

    always_comb begin
        state_d       = state_q;
        ky_d          = ky_q;
        f_d           = f_q;
        ox_d          = ox_q;
        oy_d          = oy_q;
        wrow_d        = wrow_q;
        frow_d        = frow_q;
        err_d         = err_q;
        res_we_d      = 1'b0;
        res_addr_d    = res_addr_q;
        res_spike_d   = res_spike_q;
        res_residue_d = res_residue_q;
        push          = 1'b0;
        pkt_nxt       = '0;
        unique case (state_q)
            S_IDLE: begin
                if (start_i) begin
                    state_d = S_LW_CMD;
                    err_d   = 1'b0;
                    ky_d    = '0;
                    f_d     = '0;
                    ox_d    = '0;
                    oy_d    = '0;
                end
            end
            S_LW_CMD: begin
                push    = 1'b1;
                pkt_nxt = pack_cmd(CU_ADDR, OP_LOADW, loadw_payload());
                if (out_rdy) begin
                    state_d = S_LW_FETCH;
                    f_d     = '0;
                end
            end
            S_LW_FETCH: begin
                if (f_q != 3'd0) begin
                    wrow_d[8*(f_q-3'd1) +: 8] = w_rdata_i;
                end
                if (f_q == 3'd5) begin
                    f_d     = '0;
                    state_d = S_LW_SEND;
                end else begin
                    f_d = f_q + 3'd1;
                end
            end
            S_LW_SEND: begin
                push    = 1'b1;
                pkt_nxt = pack_weight(CU_ADDR, wrow_q);
                if (out_rdy) begin
                    if (ky_q == 3'd4) begin
                        ky_d    = '0;
                        state_d = S_LW_ACK;
                    end else begin
                        ky_d    = ky_q + 3'd1;
                        state_d = S_LW_FETCH;
                    end
                end
            end
            S_LW_ACK: begin
                if (in_xfer) begin
                    if (!is_ack || ack_op != OP_LOADW) err_d = 1'b1;
                    if (is_ack) state_d = S_CFG_CMD;
                end
            end
            S_CFG_CMD: begin
                push    = 1'b1;
                pkt_nxt = pack_cmd(CU_ADDR, OP_MAC_CFG,
                                   cfg_payload(THRESHOLD));
                if (out_rdy) state_d = S_CFG_ACK;
            end
            S_CFG_ACK: begin
                if (in_xfer) begin
                    if (!is_ack || ack_op != OP_MAC_CFG) err_d = 1'b1;
                    if (is_ack) state_d = S_MAC_CMD;
                end
            end
            S_MAC_CMD: begin
                push    = 1'b1;
                pkt_nxt = pack_cmd(CU_ADDR, OP_MAC, mac_payload());
                if (out_rdy) begin
                    state_d = S_IF_FETCH;
                    f_d     = '0;
                end
            end
            S_IF_FETCH: begin
                if (f_q == 3'd0) begin
                    f_d = 3'd1;
                end else begin
                    frow_d  = 5'(if_rdata_i >> ox_q);
                    f_d     = '0;
                    state_d = S_IF_SEND;
                end
            end
            S_IF_SEND: begin
                push    = 1'b1;
                pkt_nxt = pack_fmap(CU_ADDR, frow_q);
                if (out_rdy) begin
                    if (ky_q == 3'd4) begin
                        ky_d    = '0;
                        state_d = S_WAIT_RES;
                    end else begin
                        ky_d    = ky_q + 3'd1;
                        state_d = S_IF_FETCH;
                    end
                end
            end
            S_WAIT_RES: begin
                if (in_xfer) begin
                    if (is_res) begin
                        res_we_d      = 1'b1;
                        res_addr_d    = 9'(oy_q) * 9'(OUT_DIM)
                                      + 9'(ox_q);
                        res_spike_d   = pkt_in_if.pkt[SPIKE_BIT];
                        res_residue_d = pkt_in_if.pkt[RES_LSB +: 8];
                        state_d       = S_WAIT_ACK;
                    end else begin
                        err_d = 1'b1;
                    end
                end
            end
            S_WAIT_ACK: begin
                if (in_xfer) begin
                    if (!is_ack || ack_op != OP_MAC) err_d = 1'b1;
                    if (is_ack) begin
                        state_d = S_MAC_CMD;
                        if (ox_q == LAST) begin
                            ox_d = '0;
                            if (oy_q == LAST) begin
                                oy_d    = '0;
                                state_d = S_DONE;
                            end else begin
                                oy_d = oy_q + 5'd1;
                            end
                        end else begin
                            ox_d = ox_q + 5'd1;
                        end
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= S_IDLE;
            ky_q          <= '0;
            f_q           <= '0;
            ox_q          <= '0;
            oy_q          <= '0;
            wrow_q        <= '0;
            frow_q        <= '0;
            err_q         <= 1'b0;
            res_we_q      <= 1'b0;
            res_addr_q    <= '0;
            res_spike_q   <= 1'b0;
            res_residue_q <= '0;
        end else begin
            state_q       <= state_d;
            ky_q          <= ky_d;
            f_q           <= f_d;
            ox_q          <= ox_d;
            oy_q          <= oy_d;
            wrow_q        <= wrow_d;
            frow_q        <= frow_d;
            err_q         <= err_d;
            res_we_q      <= res_we_d;
            res_addr_q    <= res_addr_d;
            res_spike_q   <= res_spike_d;
            res_residue_q <= res_residue_d;
        end
    end

    scnn_pkt_out_reg u_out (
        .clk    (clk),
        .rst    (rst),
        .push_i (push),
        .pkt_i  (pkt_nxt),
        .rdy_o  (out_rdy),
        .out_if (pkt_out_if)
    );

    assign pkt_in_if.ready = in_rdy;
    assign busy_o          = state_q != S_IDLE;
    assign done_o          = state_q == S_DONE;
    assign err_o           = err_q;
    assign res_we_o        = res_we_q;
    assign res_addr_o      = res_addr_q;
    assign res_spike_o     = res_spike_q;
    assign res_residue_o   = res_residue_q;

endmodule

// File: tb/tb_scnn_cu_sequencer.sv
// Bench for scnn_cu_sequencer: emulates memories and the CU, and
// scoreboards the packet stream and result writes.
module tb_scnn_cu_sequencer;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy, done, err;
    logic [4:0]  w_addr, if_addr;
    logic [7:0]  w_rdata = '0;
    logic [24:0] if_rdata = '0;
    logic        res_we, res_spike;
    logic [8:0]  res_addr;
    logic [7:0]  res_residue;

    always #5 clk = ~clk;

    scnn_cu_sequencer_if out_if();
    scnn_cu_sequencer_if in_if();

    scnn_cu_sequencer dut (
        .clk           (clk),
        .rst           (rst),
        .start_i       (start),
        .busy_o        (busy),
        .done_o        (done),
        .err_o         (err),
        .w_addr_o      (w_addr),
        .w_rdata_i     (w_rdata),
        .if_addr_o     (if_addr),
        .if_rdata_i    (if_rdata),
        .pkt_out_if    (out_if),
        .pkt_in_if     (in_if),
        .res_we_o      (res_we),
        .res_addr_o    (res_addr),
        .res_spike_o   (res_spike),
        .res_residue_o (res_residue)
    );

    logic [7:0]  wrom [25];
    logic [24:0] irom [25];

    always @(posedge clk) begin
        w_rdata  <= wrom[w_addr];
        if_rdata <= irom[if_addr];
    end

    int n_chk = 0;
    int n_fail = 0;
    int rx_cnt = 0;
    int done_cnt = 0;
    int rmode = 0;
    int hold_cnt = 0;
    bit hold_arm = 0;
    logic [47:0] exp_pkts[$];
    logic [17:0] exp_res[$];

    task automatic check(string name, logic [63:0] act,
                         logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic summary();
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
    endtask

    task automatic timeout(string name);
        n_chk++;
        n_fail++;
        $display("FAIL %s: timed out waiting for DUT", name);
        summary();
        $finish;
    endtask

    function automatic logic [47:0] mk(logic [2:0] t, logic [63:0] dl);
        return {5'b10000, t, dl[39:0]};
    endfunction

    // Reference stream computed straight from the packet definitions
    task automatic build_expected();
        logic [63:0] dl;
        exp_pkts.delete();
        exp_pkts.push_back(mk(3'b011, (64'd5 << 22) | (64'd1 << 12)));
        for (int ky = 0; ky < 5; ky++) begin
            dl = '0;
            for (int j = 0; j < 5; j++)
                dl = dl | (64'(wrom[ky*5+j]) << (8*j));
            exp_pkts.push_back(mk(3'b000, dl));
        end
        exp_pkts.push_back(mk(3'b011, (64'd2 << 38) | (64'd1 << 27)
                                      | (64'd32 << 18)));
        for (int oy = 0; oy < 21; oy++) begin
            for (int ox = 0; ox < 21; ox++) begin
                exp_pkts.push_back(mk(3'b011,
                    (64'd3 << 38) | (64'd5 << 21) | (64'd1 << 19)
                    | (64'd1 << 18) | (64'd1 << 8)));
                for (int ky = 0; ky < 5; ky++)
                    exp_pkts.push_back(mk(3'b001,
                        64'((irom[oy+ky] >> ox) & 25'h1f)));
            end
        end
    endtask

    // Output channel backpressure
    initial begin
        out_if.ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (hold_cnt > 0) begin
                out_if.ready = 1'b0;
                hold_cnt--;
            end else begin
                case (rmode)
                    0: out_if.ready = 1'b1;
                    1: out_if.ready = ($urandom_range(3) != 0);
                    default: out_if.ready = 1'b0;
                endcase
            end
        end
    end

    // Monitor: packet stream, hold rule, result writes, done
    initial begin
        bit          prev_stall;
        logic [47:0] prev_pkt;
        logic [17:0] er;
        prev_stall = 0;
        prev_pkt   = '0;
        forever begin
            @(negedge clk);
            if (rst) begin
                prev_stall = 0;
            end else begin
                if (prev_stall) begin
                    check("hold_valid", out_if.valid, 1);
                    check("hold_pkt", out_if.pkt, prev_pkt);
                end
                prev_stall = out_if.valid && !out_if.ready;
                prev_pkt   = out_if.pkt;
                if (out_if.valid && out_if.ready) begin
                    if (exp_pkts.size() == 0)
                        check("pkt_unexpected", out_if.pkt, 0);
                    else
                        check("pkt", out_if.pkt, exp_pkts.pop_front());
                    rx_cnt++;
                    if (hold_arm && rx_cnt == 17) begin
                        hold_cnt = 7;
                        hold_arm = 0;
                    end
                end
                if (res_we) begin
                    if (exp_res.size() == 0) begin
                        check("res_unexpected", res_we, 0);
                    end else begin
                        er = exp_res.pop_front();
                        check("res_addr", res_addr, er[17:9]);
                        check("res_spike", res_spike, er[8]);
                        check("res_residue", res_residue, er[7:0]);
                    end
                end
                if (done) begin
                    done_cnt++;
                    check("done_all_sent", exp_pkts.size(), 0);
                end
            end
        end
    end

    task automatic wait_rx(int n);
        int t;
        t = 0;
        while (rx_cnt < n) begin
            @(posedge clk);
            #1;
            t++;
            if (t > 500) timeout("wait_rx");
        end
    endtask

    task automatic send(logic [2:0] t, logic [39:0] dl);
        int c;
        in_if.pkt   = {5'b00000, t, dl};
        in_if.valid = 1'b1;
        c = 0;
        forever begin
            @(negedge clk);
            if (in_if.ready) break;
            c++;
            if (c > 500) timeout("send");
        end
        @(posedge clk);
        #1;
        in_if.valid = 1'b0;
    endtask

    task automatic run_pass(int pid, int n_pix, int bad, int stray);
        logic       s;
        logic [7:0] r;
        int         d0;
        int         ox, oy;
        build_expected();
        exp_res.delete();
        rx_cnt = 0;
        start  = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        check("busy_after_start", busy, 1);
        check("err_cleared", err, 0);
        wait_rx(6);
        send(3'b100, 40'(64'd0 << 31));
        wait_rx(7);
        send(3'b100, 40'(64'd2 << 31));
        if (pid == 1) begin
            check("err_after_cfg_ack", err, 0);
            start = 1'b1;
            @(posedge clk);
            #1;
            start = 1'b0;
        end
        for (int p = 0; p < n_pix; p++) begin
            wait_rx(7 + 6*(p+1));
            if (pid == 2)
                repeat ($urandom_range(2)) begin
                    @(posedge clk);
                    #1;
                end
            if (p == stray) send(3'b100, 40'(64'd3 << 31));
            s = 1'($urandom_range(1));
            r = 8'($urandom);
            if (pid == 1 && p == 440) begin
                s = 1'b1;
                r = 8'd17;
            end
            ox = p % 21;
            oy = p / 21;
            exp_res.push_back({9'(oy*21 + ox), s, r});
            send(3'b101, {s, r, 31'b0});
            send(3'b100, 40'(64'(p == bad ? 1 : 3) << 31));
        end
        if (n_pix == 441) begin
            d0 = done_cnt;
            for (int i = 0; i < 20 && done_cnt == d0; i++) begin
                @(posedge clk);
                #1;
            end
            check("done_count", done_cnt - d0, 1);
            check("done_one_cycle", done, 0);
            check("busy_after_done", busy, 0);
            check("res_all_written", exp_res.size(), 0);
            check("err_final", err, (bad >= 0 || stray >= 0) ? 1 : 0);
        end
    endtask

    initial begin
        rst          = 1'b1;
        start        = 1'b0;
        in_if.valid  = 1'b0;
        in_if.pkt    = '0;
        for (int i = 0; i < 25; i++) begin
            wrom[i] = 8'(i + 1);
            irom[i] = 25'h1 << i;
        end
        repeat (3) @(posedge clk);
        #1;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_err", err, 0);
        check("rst_out_valid", out_if.valid, 0);
        check("rst_out_pkt", out_if.pkt, 0);
        check("rst_in_ready", in_if.ready, 0);
        check("rst_res_we", res_we, 0);
        check("rst_res_addr", res_addr, 0);
        check("rst_res_residue", res_residue, 0);
        check("rst_w_addr", w_addr, 0);
        check("rst_if_addr", if_addr, 0);
        rst = 1'b0;
        @(posedge clk);
        #1;

        rmode    = 0;
        hold_arm = 1;
        run_pass(1, 441, -1, -1);

        for (int i = 0; i < 25; i++) begin
            wrom[i] = 8'($urandom);
            irom[i] = 25'($urandom);
        end
        rmode = 1;
        run_pass(2, 441, 100, 200);

        rmode = 0;
        run_pass(3, 1, -1, -1);
        wait_rx(16);
        rmode = 2;
        repeat (6) begin
            @(posedge clk);
            #1;
        end
        check("pre_rst_valid", out_if.valid, 1);
        check("pre_rst_busy", busy, 1);
        #3;
        rst = 1'b1;
        #1;
        check("async_rst_busy", busy, 0);
        check("async_rst_valid", out_if.valid, 0);
        check("async_rst_in_ready", in_if.ready, 0);
        exp_pkts.delete();
        exp_res.delete();
        @(posedge clk);
        #1;
        rst   = 1'b0;
        rmode = 0;
        repeat (3) begin
            @(posedge clk);
            #1;
        end
        check("post_rst_busy", busy, 0);
        check("post_rst_valid", out_if.valid, 0);
        check("post_rst_err", err, 0);

        summary();
        $finish;
    end

endmodule
